// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// RISC-V load/store size codes and request legality checks.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;

   // Stores have no unsigned variants, so 100/101 are only legal for loads.
   function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (wr && f3[2]);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: merges store data into the addressed lanes of a word
// and extracts/extends the addressed byte, half or word for loads.
module mem_lane_fmt
   import mem_resp_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] store_word,
   output logic [31:0] load_data
);

   logic [4:0]         sh;
   logic [31:0]        mask;
   logic [31:0]        shifted;
   logic signed [7:0]  b_s;
   logic signed [15:0] h_s;
   logic signed [31:0] b_ext;
   logic signed [31:0] h_ext;

   always_comb begin
      sh = 5'd0;
      case (funct3[1:0])
         2'b00:   sh = {addr_lo, 3'b000};
         2'b01:   sh = {addr_lo[1], 4'b0000};
         default: sh = 5'd0;
      endcase
      shifted = old_word >> sh;
      b_s     = shifted[7:0];
      h_s     = shifted[15:0];
      b_ext   = 32'(b_s);
      h_ext   = 32'(h_s);
      mask      = 32'hFFFF_FFFF;
      load_data = old_word;
      case (funct3[1:0])
         2'b00: begin
            mask      = 32'h0000_00FF << sh;
            load_data = funct3[2] ? {24'd0, shifted[7:0]} : b_ext;
         end
         2'b01: begin
            mask      = 32'h0000_FFFF << sh;
            load_data = funct3[2] ? {16'd0, shifted[15:0]} : h_ext;
         end
         default: begin
            mask      = 32'hFFFF_FFFF;
            load_data = old_word;
         end
      endcase
      store_word = (old_word & ~mask) | ((wdata << sh) & mask);
   end

endmodule

// File: rtl/data_mem_responder.sv
// Variable-latency data-memory slave: one load/store in flight, request and
// response each over a valid/ready handshake, access after LATENCY wait cycles.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter int          LATENCY    = 2,
   parameter logic [31:0] DATA_BASE  = DATA_BASE_DEF
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic        iReqWrite,
   input  logic [31:0] iReqAddr,
   input  logic [2:0]  iReqFunct3,
   input  logic [31:0] iReqWData,
   output logic        oRespValid,
   input  logic        iRespReady,
   output logic [31:0] oRespRData,
   output logic        oRespErr,
   output logic [1:0]  oState
);

   localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int              DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [32:0]     LIMIT    = {1'b0, DATA_BASE} + (33'd1 << (ADDR_WIDTH + 2));
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t              state, state_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic                accept, commit, req_err;

   logic [ADDR_WIDTH+1:0] addr_q, acc_addr;
   logic                  write_q, acc_write;
   logic [2:0]            f3_q, acc_f3;
   logic [31:0]           wdata_q, acc_wdata;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           old_word, store_word, load_data;

   logic [31:0] mem [DEPTH];

   // Upper bound uses 33 bits so a base near 4 GiB cannot wrap the limit.
   assign req_err = f3_illegal(iReqFunct3, iReqWrite)
                 || misaligned(iReqFunct3, iReqAddr[1:0])
                 || (iReqAddr < DATA_BASE)
                 || ({1'b0, iReqAddr} >= LIMIT);

   // With zero latency the commit happens on the accept edge, straight from the request bus.
   always_comb begin
      if (state == ST_IDLE) begin
         acc_addr  = iReqAddr[ADDR_WIDTH+1:0];
         acc_write = iReqWrite;
         acc_f3    = iReqFunct3;
         acc_wdata = iReqWData;
      end else begin
         acc_addr  = addr_q;
         acc_write = write_q;
         acc_f3    = f3_q;
         acc_wdata = wdata_q;
      end
   end

   assign idx      = acc_addr[ADDR_WIDTH+1:2] - DATA_BASE[ADDR_WIDTH+1:2];
   assign old_word = mem[idx];

   mem_lane_fmt u_fmt (
      .addr_lo    (acc_addr[1:0]),
      .funct3     (acc_f3),
      .old_word   (old_word),
      .wdata      (acc_wdata),
      .store_word (store_word),
      .load_data  (load_data)
   );

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (iReqValid) begin
               accept = 1'b1;
               if (req_err) begin
                  state_next = ST_RESP;
               end else if (LATENCY == 0) begin
                  commit     = 1'b1;
                  state_next = ST_RESP;
               end else begin
                  cnt_next   = CNT_INIT;
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               commit     = 1'b1;
               state_next = ST_RESP;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (iRespReady) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         oRespValid <= 1'b0;
         oRespRData <= '0;
         oRespErr   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept && req_err) begin
            oRespValid <= 1'b1;
            oRespErr   <= 1'b1;
            oRespRData <= '0;
         end else if (commit) begin
            oRespValid <= 1'b1;
            oRespErr   <= 1'b0;
            oRespRData <= acc_write ? 32'd0 : load_data;
         end else if ((state == ST_RESP) && iRespReady) begin
            oRespValid <= 1'b0;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (accept) begin
         addr_q  <= iReqAddr[ADDR_WIDTH+1:0];
         write_q <= iReqWrite;
         f3_q    <= iReqFunct3;
         wdata_q <= iReqWData;
      end
   end

   // A reset landing on the commit edge must suppress the write.
   always_ff @(posedge iCLK) begin
      if (commit && acc_write && iRST) mem[idx] <= store_word;
   end

   assign oReqReady = (state == ST_IDLE);
   assign oState    = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder against a byte-array
// reference model; a second zero-latency instance covers the LATENCY=0 build.
module tb_data_mem_responder;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int          LAT  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_f3 = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [1:0]  state;

   logic        z_valid = 1'b0, z_write = 1'b0, z_resp_ready = 1'b0;
   logic [31:0] z_addr = '0, z_wdata = '0;
   logic [2:0]  z_f3 = '0;
   logic        z_ready, z_rvalid, z_err;
   logic [31:0] z_rdata;
   logic [1:0]  z_state;

   int total = 0;
   int bad   = 0;

   logic [7:0] mb [0:4095];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT), .DATA_BASE(BASE)) dut (
      .iCLK(clk), .iRST(rst), .iReqValid(req_valid), .oReqReady(req_ready),
      .iReqWrite(req_write), .iReqAddr(req_addr), .iReqFunct3(req_f3),
      .iReqWData(req_wdata), .oRespValid(resp_valid), .iRespReady(resp_ready),
      .oRespRData(resp_rdata), .oRespErr(resp_err), .oState(state)
   );

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0), .DATA_BASE(BASE)) dut0 (
      .iCLK(clk), .iRST(rst), .iReqValid(z_valid), .oReqReady(z_ready),
      .iReqWrite(z_write), .iReqAddr(z_addr), .iReqFunct3(z_f3),
      .iReqWData(z_wdata), .oRespValid(z_rvalid), .iRespReady(z_resp_ready),
      .oRespRData(z_rdata), .oRespErr(z_err), .oState(z_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Reference: memory as bytes, access width 2^funct3[1:0], little-endian.
   function automatic void model(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [31:0] wd, output logic err, output logic [31:0] rd);
      longint unsigned a, v;
      int n, off;
      a   = addr;
      n   = 1 << f3[1:0];
      err = 1'b0;
      rd  = '0;
      if (a < BASE || a >= longint'(BASE) + 4096) err = 1'b1;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (wr && f3[2])) err = 1'b1;
      if (!err && (a % n) != 0) err = 1'b1;
      if (err) return;
      off = int'(a - BASE);
      if (wr) begin
         for (int k = 0; k < n; k++) mb[off + k] = wd[8*k +: 8];
      end else begin
         v = 0;
         for (int k = n - 1; k >= 0; k--) v = (v << 8) | longint'(mb[off + k]);
         if (!f3[2] && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
         rd = v[31:0];
      end
   endfunction

   task automatic xact(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input int hold);
      logic        e;
      logic [31:0] r;
      int          lat, explat;
      model(wr, addr, f3, wd, e, r);
      explat = e ? 1 : LAT + 1;
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_f3 = f3; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(explat));
      chk("resp_err", 32'(resp_err), 32'(e));
      chk("resp_rdata", resp_rdata, r);
      for (int i = 0; i < hold; i++) begin
         // A competing store to word 0 that must be ignored while busy.
         req_valid = 1'b1; req_write = 1'b1; req_addr = BASE; req_f3 = 3'b010;
         req_wdata = $urandom;
         @(posedge clk); #1;
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_rdata", resp_rdata, r);
         chk("hold_err", 32'(resp_err), 32'(e));
         chk("hold_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("post_valid", 32'(resp_valid), 32'd0);
      chk("post_state", 32'(state), 32'd0);
   endtask

   initial begin
      logic e;
      logic [31:0] r;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      xact(1'b1, BASE + 32'h4, 3'b010, 32'hDEAD_BEEF, 0);
      xact(1'b0, BASE + 32'h4, 3'b010, 32'h0, 0);
      xact(1'b1, BASE + 32'h5, 3'b000, 32'h0000_0080, 0);
      xact(1'b0, BASE + 32'h4, 3'b010, 32'h0, 0);
      xact(1'b0, BASE + 32'h5, 3'b000, 32'h0, 0);
      xact(1'b0, BASE + 32'h5, 3'b100, 32'h0, 0);
      xact(1'b0, BASE + 32'h3, 3'b001, 32'h0, 0);
      xact(1'b0, BASE + 32'h1000, 3'b010, 32'h0, 0);
      xact(1'b1, BASE + 32'h4, 3'b100, 32'h1111_1111, 0);
      xact(1'b0, BASE + 32'h4, 3'b010, 32'h0, 5);
      xact(1'b0, BASE, 3'b010, 32'h0, 0);

      xact(1'b1, BASE + 32'h8, 3'b010, 32'h1234_5678, 0);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 32'h8; req_f3 = 3'b010;
      req_wdata = 32'hAAAA_5555;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("wait_state", 32'(state), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_state", 32'(state), 32'd0);
      chk("rst_mid_valid", 32'(resp_valid), 32'd0);
      rst = 1'b1;
      xact(1'b0, BASE + 32'h8, 3'b010, 32'h0, 0);

      for (int w = 0; w < 16; w++) xact(1'b1, BASE + 32'(4*w), 3'b010, $urandom, 0);
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         logic [2:0]  f;
         case ($urandom_range(0, 11))
            0:       a = BASE - 32'd4;
            1:       a = BASE + 32'h1000 + 32'($urandom_range(0, 7));
            2:       a = 32'hFFFF_FFFC;
            default: a = BASE + 32'($urandom_range(0, 63));
         endcase
         case ($urandom_range(0, 7))
            0:       f = 3'($urandom_range(0, 7));
            1, 2:    f = 3'b000;
            3:       f = 3'b001;
            4, 5:    f = 3'b010;
            6:       f = 3'b100;
            default: f = 3'b101;
         endcase
         xact(1'($urandom_range(0, 1)), a, f, $urandom, $urandom_range(0, 2));
      end

      @(negedge clk);
      chk("z_ready", 32'(z_ready), 32'd1);
      chk("z_state_idle", 32'(z_state), 32'd0);
      z_valid = 1'b1; z_write = 1'b1; z_addr = BASE + 32'h10; z_f3 = 3'b010;
      z_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      z_valid = 1'b0;
      chk("z_sw_valid", 32'(z_rvalid), 32'd1);
      chk("z_sw_state", 32'(z_state), 32'd2);
      chk("z_sw_err", 32'(z_err), 32'd0);
      chk("z_sw_rdata", z_rdata, 32'd0);
      @(negedge clk);
      z_resp_ready = 1'b1;
      @(posedge clk); #1;
      z_resp_ready = 1'b0;
      chk("z_sw_done", 32'(z_state), 32'd0);
      chk("z_sw_vlow", 32'(z_rvalid), 32'd0);
      @(negedge clk);
      z_valid = 1'b1; z_write = 1'b0; z_addr = BASE + 32'h10; z_f3 = 3'b010;
      @(posedge clk); #1;
      z_valid = 1'b0;
      chk("z_lw_valid", 32'(z_rvalid), 32'd1);
      chk("z_lw_state", 32'(z_state), 32'd2);
      chk("z_lw_rdata", z_rdata, 32'hCAFE_F00D);
      @(negedge clk);
      z_resp_ready = 1'b1;
      @(posedge clk); #1;
      z_resp_ready = 1'b0;
      chk("z_lw_done", 32'(z_state), 32'd0);

      model(1'b0, BASE, 3'b010, 32'h0, e, r);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the multicycle CPU's data port: accepts one load/store request at a time over a valid/ready handshake.
- Performs the access against an internal word array after a programmable latency, and returns formatted read data or an error over a second valid/ready handshake.
- Sits between the CPU's data-address path and the data segment. It replaces the fixed one-cycle RAM with a variable-latency slave so the control FSM's wait states can be exercised.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, extra wait cycles between request acceptance and access commit (0 allowed).
- DATA_BASE, 32'h1001_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- iCLK  input  1  CPU clock; all state changes on rising edge.
- iRST  input  1  reset, synchronous, active-low.
- iReqValid  input  1  request present.
- oReqReady  output  1  responder can accept a request (high only in IDLE).
- iReqWrite  input  1  1 = store, 0 = load.
- iReqAddr  input  32  byte address.
- iReqFunct3  input  3  RISC-V size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- iReqWData  input  32  store data, right-aligned (byte/half in low bits).
- oRespValid  output  1  response present.
- iRespReady  input  1  requester takes response.
- oRespRData  output  32  load result, sign/zero extended; 0 for stores and errors.
- oRespErr  output  1  request rejected (misaligned, out of range, illegal funct3).
- oState  output  2  FSM state for the debug display: 0 IDLE, 1 WAIT, 2 RESP.

Behaviour:
- States: IDLE, WAIT, RESP. Registered outputs: oRespValid, oRespRData, oRespErr. oReqReady = (state==IDLE).
- Reset (iRST low at a rising edge):
  - state IDLE, oRespValid 0, oRespRData 0, oRespErr 0, counter 0.
  - Array contents are not cleared.
  - An in-flight request is dropped; a store not yet committed never writes.
- IDLE:
  - On iReqValid at the edge, capture addr, write, funct3, wdata, and check for errors.
  - On error: go to RESP with oRespErr=1, oRespRData=0; no array access.
  - Otherwise, if LATENCY==0, commit at this same edge and go to RESP. If LATENCY>0, load counter=LATENCY-1 and go to WAIT.
- Error conditions, any one of which sets oRespErr:
  - Misaligned: h/hu with addr[0]≠0, or w with addr[1:0]≠0.
  - Out of range: addr < DATA_BASE or addr ≥ DATA_BASE + 4·2^ADDR_WIDTH.
  - Illegal funct3: 011, 110, 111, or a store with 100/101.
- WAIT: counter decrements each cycle. When counter==0, commit and go to RESP.
- Commit:
  - Word index = (addr − DATA_BASE)[ADDR_WIDTH+1:2].
  - Store: byte-lane merge (b: lane addr[1:0]; h: lanes addr[1]*2, +1; w: all four). Other bytes are unchanged. oRespRData=0.
  - Load: extract the addressed byte/half/word; sign-extend for b/h, zero-extend for bu/hu.
- Latency: valid request accepted at edge T → oRespValid rises at edge T+LATENCY+1. Error responses rise at edge T+1.
- RESP:
  - oRespValid, oRespRData and oRespErr are held stable until iRespReady is sampled high.
  - On that edge, clear oRespValid and go to IDLE.
  - No new request is accepted in the same edge; back-to-back requests have at least 1 idle cycle.
- iReqValid while not in IDLE is ignored (oReqReady low); the requester must hold it.
- A load immediately after a store to the same word returns the merged value; there are no hazards because only one transaction is outstanding.
- Address arithmetic: 32-bit unsigned. The upper-bound compare must not overflow for DATA_BASE near the top of the address space; use a 33-bit compare.

Decomposition:
- Package mem_resp_pkg:
  - State enum (IDLE/WAIT/RESP, 2 bits).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Default DATA_BASE constant.
- Sub-module mem_lane_fmt (combinational): given addr[1:0], funct3, old word and wdata, produces the merged store word and the formatted load value. It is instantiated once and is unit-testable on its own.

Test Plan:
- Store w 32'hDEADBEEF to 0x1001_0004, then load w, LATENCY=2 → store response rises 3 cycles after accept with err=0, rdata=0; load returns 32'hDEADBEEF.
- Store b 8'h80 to 0x1001_0005 over 0xDEADBEEF, then lb and lbu at 0x1001_0005 → word becomes 0xDEAD80EF; lb=0xFFFFFF80, lbu=0x00000080.
- Load h at 0x1001_0003, and load w at 0x1001_1000 (ADDR_WIDTH=10) → each gets err=1, rdata=0, valid 1 cycle after accept; array unchanged.
- Hold iRespReady low 5 cycles after a load → oRespValid/oRespRData are stable all 5 cycles, oReqReady=0, and a second request is not accepted until 1 cycle after the handshake.
- Assert iRST low during WAIT of a store to 0x1001_0008 (prior value 0x12345678) → next cycle state IDLE, oRespValid=0; a later load returns 0x12345678.
- LATENCY=0 build, lw after sw → response rises 1 cycle after accept; oState sequence 0→2→0.
